serial_adder: RTL

- Bit-serial N-bit adder built around one full-adder cell and a carry flip-flop.
- Processes operands LSB-first, one bit per clock; result is collected in a shift register.
- Forward-arithmetic counterpart of the team's full-subtractor cell. Used where area matters more than latency.
- Start/busy/done handshake toward the controlling logic.

---
 rtl/serial_adder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from a single full-adder cell and a
// carry flip-flop. Operands are consumed LSB-first, one bit per clock, and the result
// is collected in a right-shifting sum register.
//
// Optional build macro: SERIAL_SUB_EN
//   When defined, adds input `sub`. With sub=1 the cell becomes a full subtractor
//   (a - b - cin, cin acting as borrow-in, cout reporting the final borrow).
//   Otherwise the block is adder-only and `sub` does not exist.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   operation request, sampled only while idle
//   a, b   in   WIDTH-bit operands, latched when start is accepted
//   cin    in   carry-in (borrow-in when subtracting), latched with the operands
//   sub    in   (SERIAL_SUB_EN only) select subtraction, latched with the operands
//   busy   out  high during the WIDTH bit-processing cycles
//   done   out  one-cycle pulse; sum/cout are final
//   sum    out  result, held until the next accepted start
//   cout   out  final carry (or borrow), held with sum

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_bit;

    // Full-adder / full-subtractor cell.
    logic              cell_a;
    logic              cell_b;
    logic              cell_s;
    logic              cell_c_next;

`ifdef SERIAL_SUB_EN
    logic              sub_q, sub_d;
`endif

    assign cell_a   = a_q[0];
    assign cell_b   = b_q[0];
    assign cell_s   = cell_a ^ cell_b ^ carry_q;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
    // Difference bit equals the sum bit; only the carry/borrow term differs.
    always_comb begin
        if (sub_q) begin
            cell_c_next = (~cell_a & cell_b) | (~cell_a & carry_q) | (cell_b & carry_q);
        end else begin
            cell_c_next = (cell_a & cell_b) | (cell_a & carry_q) | (cell_b & carry_q);
        end
    end
`else
    assign cell_c_next = (cell_a & cell_b) | (cell_a & carry_q) | (cell_b & carry_q);
`endif

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_EN
        sub_d   = sub_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = StRun;
                end
            end

            StRun: begin
                // Result enters at the MSB, so after WIDTH shifts bit 0 is the LSB.
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cell_c_next;
                if (last_bit) begin
                    cout_d  = cell_c_next;
                    // Explicit wrap: WIDTH need not be a power of two.
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
